fractional_rotation_ctrl: RTL and testbench

//  Parametrised move controller for the stepper path. It runs a fixed-length move of 1/4, 1/2 or 1

---
 rtl/fractional_rotation_ctrl_if.sv | 34 +++
 rtl/fractional_rotation_ctrl.sv | 139 +++++++++++++
 tb/tb_fractional_rotation_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/fractional_rotation_ctrl_if.sv
// Key/switch request side and status side of the stepper move controller.
// The controller takes the slave view. The driving logic takes the master view.
interface fractional_rotation_ctrl_if #(
  parameter int CNT_W = 16
) ();
  logic             trigger;
  logic             cont_enable;
  logic             step_pulse;
  logic             step_size;
  logic [1:0]       frac_sel;
  logic [CNT_W-1:0] custom_steps;
  logic             dir_in;
  logic             abort;
  logic             move_active;
  logic             move_dir;
  logic             move_done;
  logic             move_aborted;
  logic             req_pending;
  logic [CNT_W-1:0] steps_done;

  modport master (
    output trigger, cont_enable, step_pulse, step_size,
    output frac_sel, custom_steps, dir_in, abort,
    input  move_active, move_dir, move_done, move_aborted,
    input  req_pending, steps_done
  );

  modport slave (
    input  trigger, cont_enable, step_pulse, step_size,
    input  frac_sel, custom_steps, dir_in, abort,
    output move_active, move_dir, move_done, move_aborted,
    output req_pending, steps_done
  );
endinterface

// File: rtl/fractional_rotation_ctrl.sv
// Fixed-length stepper move controller: quarter/half/full rev or custom count.
// It holds one queued request and supports abort.
module fractional_rotation_ctrl #(
  parameter int STEPS_PER_REV = 200,
  parameter int CNT_W         = 16
) (
  input logic                    clk,
  input logic                    reset_n,
  fractional_rotation_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam logic [CNT_W-1:0] QTR = CNT_W'(STEPS_PER_REV / 4);

  state_e           state_q, state_d;
  logic             trig_prev_q, trig_prev_d;
  logic             armed_q, armed_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic [CNT_W-1:0] steps_q, steps_d;
  logic             dir_q, dir_d;
  logic             active_q, active_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;
  logic             pend_q, pend_d;

  logic             req;
  logic             start;
  logic [CNT_W-1:0] base;
  logic [CNT_W-1:0] new_tgt;
  logic [CNT_W-1:0] steps_inc;

  // A key held low across reset must not look like a fresh press
  assign req = armed_q & trig_prev_q & ~bus.trigger
             & ~bus.cont_enable & ~bus.abort;
  assign start = req
               | (pend_q & ~bus.cont_enable & ~bus.abort);
  assign steps_inc = steps_q + CNT_W'(1);

  always_comb begin
    base = QTR;
    unique case (bus.frac_sel)
      2'b00:   base = QTR;
      2'b01:   base = QTR << 1;
      default: base = QTR << 2;
    endcase
    if (bus.frac_sel == 2'b11)
      new_tgt = bus.custom_steps;
    else if (bus.step_size)
      new_tgt = base;
    else
      new_tgt = base << 1;
  end

  always_comb begin
    state_d     = state_q;
    trig_prev_d = bus.trigger;
    armed_d     = 1'b1;
    target_d    = target_q;
    steps_d     = steps_q;
    dir_d       = dir_q;
    active_d    = active_q;
    done_d      = 1'b0;
    aborted_d   = 1'b0;
    pend_d      = pend_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          pend_d = 1'b0;
          if (new_tgt != '0) begin
            state_d  = RUN;
            target_d = new_tgt;
            steps_d  = '0;
            dir_d    = bus.dir_in;
            active_d = 1'b1;
          end
        end else if (bus.abort) begin
          pend_d = 1'b0;
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_d   = IDLE;
          active_d  = 1'b0;
          aborted_d = 1'b1;
          pend_d    = 1'b0;
        end else begin
          if (req) pend_d = 1'b1;
          if (bus.step_pulse) begin
            steps_d = steps_inc;
            if (steps_inc == target_q) begin
              state_d  = DONE;
              active_d = 1'b0;
              done_d   = 1'b1;
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        if (bus.abort) pend_d = 1'b0;
        else if (req)  pend_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      trig_prev_q <= 1'b1;
      armed_q     <= 1'b0;
      target_q    <= '0;
      steps_q     <= '0;
      dir_q       <= 1'b0;
      active_q    <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      pend_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      trig_prev_q <= trig_prev_d;
      armed_q     <= armed_d;
      target_q    <= target_d;
      steps_q     <= steps_d;
      dir_q       <= dir_d;
      active_q    <= active_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
      pend_q      <= pend_d;
    end
  end

  assign bus.move_active  = active_q;
  assign bus.move_dir     = dir_q;
  assign bus.move_done    = done_q;
  assign bus.move_aborted = aborted_q;
  assign bus.req_pending  = pend_q;
  assign bus.steps_done   = steps_q;
endmodule

// File: tb/tb_fractional_rotation_ctrl.sv
// Directed and random checks of the move controller
// against a behavioural reference model.
module tb_fractional_rotation_ctrl;
  localparam int SPR = 200;
  localparam int W   = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fractional_rotation_ctrl_if #(.CNT_W(W)) bus ();

  fractional_rotation_ctrl #(
    .STEPS_PER_REV(SPR),
    .CNT_W(W)
  ) dut (
    .clk(clk),
    .reset_n(rst_n),
    .bus(bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Model of the move: busy/done phase, counts, queue flag
  bit m_run, m_done, m_donep, m_abp, m_pend, m_dir, m_prev, m_arm;
  int m_cnt, m_target;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d @%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int target_of(int fs, bit ss, int cs);
    if (fs == 3) return cs;
    return (SPR * (1 << fs) / 4) * (ss ? 1 : 2);
  endfunction

  task automatic model_reset();
    m_run = 0; m_done = 0; m_donep = 0; m_abp = 0;
    m_pend = 0; m_dir = 0; m_cnt = 0; m_target = 0;
    m_prev = 1; m_arm = 0;
  endtask

  task automatic model_step();
    bit req;
    int t;
    req = m_arm && m_prev && !bus.trigger
        && !bus.cont_enable && !bus.abort;
    m_donep = 0;
    m_abp = 0;
    if (m_run) begin
      if (bus.abort) begin
        m_run = 0; m_abp = 1; m_pend = 0;
      end else begin
        if (req) m_pend = 1;
        if (bus.step_pulse) begin
          m_cnt++;
          if (m_cnt == m_target) begin
            m_run = 0; m_done = 1; m_donep = 1;
          end
        end
      end
    end else if (m_done) begin
      m_done = 0;
      if (bus.abort) m_pend = 0;
      else if (req) m_pend = 1;
    end else if (req || (m_pend && !bus.cont_enable && !bus.abort)) begin
      m_pend = 0;
      t = target_of(int'(bus.frac_sel), bus.step_size,
                    int'(bus.custom_steps));
      if (t != 0) begin
        m_run = 1; m_target = t; m_cnt = 0; m_dir = bus.dir_in;
      end
    end else if (bus.abort) begin
      m_pend = 0;
    end
    m_prev = bus.trigger;
    m_arm = 1;
  endtask

  task automatic compare_all();
    check("move_active",  bus.move_active,  m_run);
    check("move_dir",     bus.move_dir,     m_dir);
    check("move_done",    bus.move_done,    m_donep);
    check("move_aborted", bus.move_aborted, m_abp);
    check("req_pending",  bus.req_pending,  m_pend);
    check("steps_done",   bus.steps_done,   m_cnt);
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst_n) model_step();
    else model_reset();
    @(negedge clk);
    compare_all();
  endtask

  task automatic press();
    bus.trigger = 1'b0;
    cyc();
    bus.trigger = 1'b1;
    cyc();
  endtask

  task automatic steps(int n);
    for (int i = 0; i < n; i++) begin
      bus.step_pulse = 1'b1;
      cyc();
    end
    bus.step_pulse = 1'b0;
  endtask

  initial begin
    bus.trigger = 1'b1; bus.cont_enable = 1'b0;
    bus.step_pulse = 1'b0; bus.step_size = 1'b1;
    bus.frac_sel = 2'b00; bus.custom_steps = '0;
    bus.dir_in = 1'b0; bus.abort = 1'b0;
    model_reset();
    repeat (3) cyc();
    rst_n = 1'b1;
    repeat (2) cyc();

    // quarter rev, full step
    bus.dir_in = 1'b1;
    press();
    steps(49);
    check("t1_active49", bus.move_active, 1);
    steps(1);
    check("t1_done", bus.move_done, 1);
    check("t1_steps", bus.steps_done, 50);
    check("t1_inactive", bus.move_active, 0);
    repeat (3) cyc();

    // full rev half step, inputs changed mid-move
    bus.frac_sel = 2'b10; bus.step_size = 1'b0; bus.dir_in = 1'b0;
    press();
    bus.step_size = 1'b1; bus.dir_in = 1'b1;
    steps(399);
    check("t2_active399", bus.move_active, 1);
    steps(1);
    check("t2_done", bus.move_done, 1);
    check("t2_steps", bus.steps_done, 400);
    check("t2_dir", bus.move_dir, 0);
    repeat (3) cyc();

    // queueing: second edge queued, third dropped
    bus.frac_sel = 2'b00;
    press();
    steps(20);
    press();
    check("t3_pend", bus.req_pending, 1);
    press();
    steps(30);
    check("t3_done", bus.move_done, 1);
    check("t3_pend_kept", bus.req_pending, 1);
    cyc();
    check("t3_gap", bus.move_active, 0);
    cyc();
    check("t3_restart", bus.move_active, 1);
    check("t3_pend_clr", bus.req_pending, 0);
    steps(50);
    check("t3_no_third", bus.req_pending, 0);
    repeat (3) cyc();

    // abort at step 30 of half move
    bus.frac_sel = 2'b01;
    press();
    steps(10);
    press();
    steps(20);
    bus.abort = 1'b1;
    bus.step_pulse = 1'b1;
    cyc();
    bus.abort = 1'b0;
    bus.step_pulse = 1'b0;
    check("t4_aborted", bus.move_aborted, 1);
    check("t4_steps", bus.steps_done, 30);
    check("t4_pend", bus.req_pending, 0);
    check("t4_nodone", bus.move_done, 0);
    repeat (3) cyc();

    // blocked starts
    bus.cont_enable = 1'b1;
    press();
    check("t5_cont", bus.move_active, 0);
    bus.cont_enable = 1'b0;
    bus.frac_sel = 2'b11; bus.custom_steps = '0;
    press();
    steps(3);
    check("t5_zero", bus.move_active, 0);
    check("t5_zero_q", bus.req_pending, 0);

    // reset mid-move, key held low through reset
    bus.frac_sel = 2'b01;
    press();
    steps(10);
    #2 rst_n = 1'b0;
    #1;
    check("t6_active", bus.move_active, 0);
    check("t6_steps", bus.steps_done, 0);
    check("t6_dir", bus.move_dir, 0);
    check("t6_pend", bus.req_pending, 0);
    model_reset();
    bus.trigger = 1'b0;
    @(negedge clk);
    repeat (2) cyc();
    rst_n = 1'b1;
    repeat (4) cyc();
    check("t6_held_low", bus.move_active, 0);
    bus.trigger = 1'b1;
    cyc();

    // random traffic against the model
    for (int i = 0; i < 15000; i++) begin
      if ($urandom_range(0, 5) == 0) bus.trigger = ~bus.trigger;
      bus.step_pulse   = ($urandom_range(0, 9) < 6);
      bus.abort        = ($urandom_range(0, 299) == 0);
      bus.cont_enable  = ($urandom_range(0, 29) == 0);
      bus.step_size    = ($urandom_range(0, 3) != 0);
      bus.frac_sel     = 2'($urandom_range(0, 3));
      bus.custom_steps = W'($urandom_range(0, 40));
      bus.dir_in       = 1'($urandom);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
